// File: rtl/fwd_hazard_unit_if.sv
// Bundle between the ID/EX pipeline control and the forwarding/hazard unit.
// Parameters must match the ones given to fwd_hazard_unit.
interface fwd_hazard_unit_if #(
    parameter int AW    = 5,
    parameter int NSRC  = 2,
    parameter int NFWD  = 2,
    parameter int CNT_W = 16
);
    localparam int SELW = $clog2(NFWD + 1);

    logic [NSRC*AW-1:0]   id_src_i;
    logic [NSRC-1:0]      id_src_vld_i;
    logic [AW-1:0]        ex_rd_i;
    logic                 ex_wb_i;
    logic                 ex_memrd_i;
    logic [NFWD*AW-1:0]   fwd_rd_i;
    logic [NFWD-1:0]      fwd_wb_i;
    logic                 hold_i;
    logic                 flush_i;
    logic                 stall_o;
    logic [NSRC*SELW-1:0] ex_fwd_sel_o;
    logic [CNT_W-1:0]     stall_cnt_o;

    modport slave (
        input  id_src_i, id_src_vld_i, ex_rd_i, ex_wb_i, ex_memrd_i,
               fwd_rd_i, fwd_wb_i, hold_i, flush_i,
        output stall_o, ex_fwd_sel_o, stall_cnt_o
    );

    modport master (
        output id_src_i, id_src_vld_i, ex_rd_i, ex_wb_i, ex_memrd_i,
               fwd_rd_i, fwd_wb_i, hold_i, flush_i,
        input  stall_o, ex_fwd_sel_o, stall_cnt_o
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding select precompute and load-use stall control. Selects are decided
// in ID and registered into ID/EX so EX only muxes.
module fwd_sel_lane #(
    parameter int AW   = 5,
    parameter int NFWD = 2,
    parameter int SELW = 2
) (
    input  logic [AW-1:0]      src,
    input  logic               srcVld,
    input  logic [AW-1:0]      exRd,
    input  logic               exWb,
    input  logic [NFWD*AW-1:0] fwdRd,
    input  logic [NFWD-1:0]    fwdWb,
    output logic [SELW-1:0]    nextSel,
    output logic               exHit
);
    assign exHit = srcVld && exWb && (exRd != '0) && (exRd == src);

    // Walk oldest-to-youngest so the youngest forwardable stage is left standing;
    // the oldest stage has already written the regfile and is skipped.
    always_comb begin
        nextSel = '0;
        for (int k = NFWD - 2; k >= 0; k--) begin
            if (srcVld && fwdWb[k] && (fwdRd[k*AW +: AW] != '0) &&
                (fwdRd[k*AW +: AW] == src))
                nextSel = SELW'(k + 2);
        end
        if (exHit)
            nextSel = SELW'(1);
    end
endmodule

module fwd_hazard_unit #(
    parameter int AW       = 5,
    parameter int NSRC     = 2,
    parameter int NFWD     = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    fwd_hazard_unit_if.slave bus
);
    localparam int SELW = $clog2(NFWD + 1);
    localparam int LCW  = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    typedef enum logic {IDLE, STALL} state_t;

    state_t                     state, stateNxt;
    logic [LCW-1:0]             cnt, cntNxt;
    logic [NSRC-1:0][SELW-1:0]  nextSel;
    logic [NSRC-1:0][SELW-1:0]  selQ;
    logic [NSRC-1:0]            exHit;
    logic                       loadHaz;
    logic                       stall;
    logic [CNT_W-1:0]           stallCnt;

    for (genvar j = 0; j < NSRC; j++) begin : gLane
        fwd_sel_lane #(.AW(AW), .NFWD(NFWD), .SELW(SELW)) uLane (
            .src     (bus.id_src_i[j*AW +: AW]),
            .srcVld  (bus.id_src_vld_i[j]),
            .exRd    (bus.ex_rd_i),
            .exWb    (bus.ex_wb_i),
            .fwdRd   (bus.fwd_rd_i),
            .fwdWb   (bus.fwd_wb_i),
            .nextSel (nextSel[j]),
            .exHit   (exHit[j])
        );
    end

    assign loadHaz = bus.ex_memrd_i && (|exHit);

    always_comb begin
        stall = 1'b0;
        if (rst_i && !bus.flush_i)
            stall = (state == STALL) ? 1'b1 : loadHaz;
    end

    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        if (bus.flush_i) begin
            stateNxt = IDLE;
            cntNxt   = '0;
        end else if (!bus.hold_i) begin
            case (state)
                IDLE: begin
                    if (loadHaz && (LOAD_LAT > 1)) begin
                        stateNxt = STALL;
                        cntNxt   = LCW'(LOAD_LAT - 1);
                    end
                end
                STALL: begin
                    if (cnt == LCW'(1)) begin
                        stateNxt = IDLE;
                        cntNxt   = '0;
                    end else begin
                        cntNxt = cnt - LCW'(1);
                    end
                end
                default: begin
                    stateNxt = IDLE;
                    cntNxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNxt;
            cnt   <= cntNxt;
        end
    end

    // Stalled ID instruction is not issued, so EX gets a bubble with select 0.
    always_ff @(posedge clk_i) begin
        if (!rst_i || bus.flush_i)
            selQ <= '0;
        else if (!bus.hold_i)
            selQ <= stall ? '0 : nextSel;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            stallCnt <= '0;
        else if (stall && !bus.hold_i && (stallCnt != '1))
            stallCnt <= stallCnt + CNT_W'(1);
    end

    assign bus.stall_o      = stall;
    assign bus.ex_fwd_sel_o = selQ;
    assign bus.stall_cnt_o  = stallCnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: comb stall checked in-cycle, registered selects via a scoreboard queue.
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct { string tag; logic [3:0] sel; } exp_t;
    exp_t sb[$];

    fwd_hazard_unit_if #(.AW(5), .NSRC(2), .NFWD(2), .CNT_W(16)) tif ();
    fwd_hazard_unit_if #(.AW(5), .NSRC(2), .NFWD(2), .CNT_W(2))  tifB ();

    assign tifB.id_src_i     = tif.id_src_i;
    assign tifB.id_src_vld_i = tif.id_src_vld_i;
    assign tifB.ex_rd_i      = tif.ex_rd_i;
    assign tifB.ex_wb_i      = tif.ex_wb_i;
    assign tifB.ex_memrd_i   = tif.ex_memrd_i;
    assign tifB.fwd_rd_i     = tif.fwd_rd_i;
    assign tifB.fwd_wb_i     = tif.fwd_wb_i;
    assign tifB.hold_i       = tif.hold_i;
    assign tifB.flush_i      = tif.flush_i;

    fwd_hazard_unit #(.AW(5), .NSRC(2), .NFWD(2), .LOAD_LAT(3), .CNT_W(16)) dut (
        .clk_i (clk), .rst_i (rst), .bus (tif.slave)
    );
    fwd_hazard_unit #(.AW(5), .NSRC(2), .NFWD(2), .LOAD_LAT(1), .CNT_W(2)) dutB (
        .clk_i (clk), .rst_i (rst), .bus (tifB.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs already driven; check comb stall, queue the select due after the edge.
    task automatic step(input string tag, input logic expStall, input logic [3:0] expSel);
        exp_t e;
        #1;
        chk({tag, ".stall"}, 32'(tif.stall_o), 32'(expStall));
        sb.push_back('{tag, expSel});
        @(posedge clk); #1;
        e = sb.pop_front();
        chk({e.tag, ".sel"}, 32'(tif.ex_fwd_sel_o), 32'(e.sel));
    endtask

    task automatic clr();
        tif.id_src_i = '0; tif.id_src_vld_i = '0; tif.ex_rd_i = '0;
        tif.ex_wb_i = 1'b0; tif.ex_memrd_i = 1'b0; tif.fwd_rd_i = '0;
        tif.fwd_wb_i = '0; tif.hold_i = 1'b0; tif.flush_i = 1'b0;
    endtask

    task automatic loadUse();
        tif.ex_rd_i = 5'd7; tif.ex_wb_i = 1'b1; tif.ex_memrd_i = 1'b1;
        tif.id_src_i = {5'd4, 5'd7}; tif.id_src_vld_i = 2'b11;
    endtask

    task automatic exBubble();
        tif.ex_rd_i = '0; tif.ex_wb_i = 1'b0; tif.ex_memrd_i = 1'b0;
    endtask

    task automatic doReset(input string tag);
        clr();
        rst = 1'b0;
        step(tag, 1'b0, 4'b0000);
        chk({tag, ".cnt"}, 32'(tif.stall_cnt_o), 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        clr();
        @(posedge clk); #1;
        // Reset with a live load-use hazard on the inputs: stall must stay low.
        rst = 1'b0;
        loadUse();
        step("rst", 1'b0, 4'b0000);
        chk("rst.cnt", 32'(tif.stall_cnt_o), 32'd0);
        chk("rst.cntB", 32'(tifB.stall_cnt_o), 32'd0);
        clr();
        rst = 1'b1;

        // R-type chain through EX
        tif.ex_rd_i = 5'd3; tif.ex_wb_i = 1'b1;
        tif.id_src_i = {5'd0, 5'd3}; tif.id_src_vld_i = 2'b01;
        step("rchain", 1'b0, 4'b0001);
        tif.hold_i = 1'b1; tif.ex_wb_i = 1'b0;
        step("holdSel", 1'b0, 4'b0001);
        tif.hold_i = 1'b0;

        // Priority: EX beats stage 0, stage 0 forwards, oldest stage does not
        clr();
        tif.ex_rd_i = 5'd5; tif.ex_wb_i = 1'b1;
        tif.fwd_rd_i = {5'd0, 5'd5}; tif.fwd_wb_i = 2'b01;
        tif.id_src_i = {5'd5, 5'd9}; tif.id_src_vld_i = 2'b11;
        step("prioEx", 1'b0, 4'b0100);
        tif.ex_wb_i = 1'b0;
        step("prioS0", 1'b0, 4'b1000);
        tif.fwd_rd_i = {5'd5, 5'd0}; tif.fwd_wb_i = 2'b10;
        step("prioOld", 1'b0, 4'b0000);
        tif.fwd_rd_i = {5'd0, 5'd5}; tif.fwd_wb_i = 2'b01; tif.id_src_vld_i = 2'b01;
        step("noVld", 1'b0, 4'b0000);

        // Register 0 never forwards or stalls
        clr();
        tif.ex_rd_i = 5'd0; tif.ex_wb_i = 1'b1; tif.ex_memrd_i = 1'b1;
        tif.id_src_vld_i = 2'b01;
        step("zero", 1'b0, 4'b0000);

        // Load-use with LOAD_LAT=3, other operand forwardable from stage 0
        clr();
        loadUse();
        tif.fwd_rd_i = {5'd0, 5'd4}; tif.fwd_wb_i = 2'b01;
        step("lu0", 1'b1, 4'b0000);
        exBubble();
        step("lu1", 1'b1, 4'b0000);
        step("lu2", 1'b1, 4'b0000);
        tif.fwd_rd_i = {5'd4, 5'd7}; tif.fwd_wb_i = 2'b11;
        step("luRel", 1'b0, 4'b0010);
        chk("lu.cnt", 32'(tif.stall_cnt_o), 32'd3);

        // Hold for two cycles mid-stall stretches stall but not the counter
        doReset("rst5");
        loadUse();
        step("h0", 1'b1, 4'b0000);
        exBubble();
        tif.hold_i = 1'b1;
        step("h1", 1'b1, 4'b0000);
        step("h2", 1'b1, 4'b0000);
        tif.hold_i = 1'b0;
        step("h3", 1'b1, 4'b0000);
        step("h4", 1'b1, 4'b0000);
        tif.fwd_rd_i = {5'd0, 5'd7}; tif.fwd_wb_i = 2'b01;
        step("h5", 1'b0, 4'b0010);
        chk("hold.cnt", 32'(tif.stall_cnt_o), 32'd3);

        // Flush inside STALL
        doReset("rst6");
        loadUse();
        step("f0", 1'b1, 4'b0000);
        tif.flush_i = 1'b1;
        step("f1", 1'b0, 4'b0000);
        tif.flush_i = 1'b0;
        exBubble();
        step("f2", 1'b0, 4'b0000);
        chk("flush.cnt", 32'(tif.stall_cnt_o), 32'd1);

        // Reset inside STALL
        loadUse();
        step("r0", 1'b1, 4'b0000);
        chk("r0.cnt", 32'(tif.stall_cnt_o), 32'd2);
        rst = 1'b0;
        exBubble();
        step("r1", 1'b0, 4'b0000);
        chk("r1.cnt", 32'(tif.stall_cnt_o), 32'd0);
        rst = 1'b1;
        step("r2", 1'b0, 4'b0000);

        // 2-bit counter saturates over five single-cycle stalls
        doReset("rst7");
        loadUse();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("sat.stall%0d", i), 32'(tifB.stall_o), 32'd1);
            @(posedge clk); #1;
            if (i == 2) chk("sat.cnt3", 32'(tifB.stall_cnt_o), 32'd3);
        end
        chk("sat.cnt", 32'(tifB.stall_cnt_o), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
